usb_fs_rx: RTL and testbench
============================

# usb_fs_rx

Full-speed USB receive front end for one port of the proxy. It samples the raw D+/D− pair at 4× bit rate and recovers bit timing from line transitions. It performs NRZI decoding, SYNC detection and bit unstuffing, and delivers received bytes with PID, end-of-packet, error and bus-reset indications. One instance sits on each port, host-side and device-side, directly upstream of the proxy's packet-tracking and direction logic.

## Interface
Parameters:
- RESET_CLKS, 120: consecutive SE0 clocks before `usb_reset` asserts (2.5 µs at 48 MHz).
- IDLE_BITS, 8: consecutive J bit periods needed to leave ERROR.

Ports:
- clk  in  1  48 MHz sample clock, 4× the 12 Mb/s bit rate.
- rst  in  1  reset; synchronous, active-high.
- dp  in  1  raw D+, asynchronous.
- dm  in  1  raw D−, asynchronous.
- rx_active  out  1  high from SYNC acceptance until the packet ends or errors.
- rx_valid  out  1  one-clk strobe; `rx_data` holds a complete byte.
- rx_data  out  8  received byte, LSB first on the wire.
- rx_pid  out  1  qualifies `rx_valid`: this byte is the PID.
- rx_eop  out  1  one-clk strobe on a clean end of packet.
- rx_error  out  1  one-clk strobe on any receive error.
- usb_reset  out  1  level; SE0 has been held for at least RESET_CLKS clocks.

## Operation
- **Input synchronizer.** dp and dm each pass through a 2-flop synchronizer.
- **Line states** (synchronized values):
  - J: dp=1, dm=0.
  - K: dp=0, dm=1.
  - SE0: both 0.
  - SE1: both 1, treated as SE0 for the EOP check and as an error in any other state.
- **Clock recovery.**
  - A 2-bit phase counter increments every clk and wraps from 3 to 0.
  - The counter loads 0 in any clk where the synchronized line state differs from the previous clk.
  - The sample strobe fires when phase==2.
  - All logic below advances only on strobes, except `usb_reset`.
- **NRZI decode.** Decoded bit = 1 if the sampled state equals the previous sampled state, 0 otherwise. The previous sampled state resets to J.
- **FSM states.**
  - IDLE: the first sampled K goes to SYNC. This first K decodes as bit 0.
  - SYNC:
    - Eight decoded bits must be 0,0,0,0,0,0,0,1.
    - On the 8th bit matching, `rx_active` goes to 1 and the FSM goes to DATA.
    - Any mismatch, or SE0/SE1, goes to ERROR.
  - DATA:
    - A ones counter (0..6) runs on decoded bits.
    - When the counter reaches 6, the next bit is a stuff bit:
      - 0: discarded, counter cleared.
      - 1: stuff error, go to ERROR.
    - Bits that are not stuff bits shift into the byte register LSB first. The 8th such bit completes the byte.
    - The first byte of a packet is the PID.
    - SE0/SE1 goes to EOP.
  - EOP:
    - Entered with zero pending bits: clean end, `rx_eop` pulses.
    - Entered with 1–7 pending bits: `rx_error` pulses.
    - Either way `rx_active` drops and the FSM waits for a sampled J, then goes to IDLE.
    - A sampled K in EOP goes to ERROR.
  - ERROR:
    - `rx_error` pulses once on entry and `rx_active` drops.
    - Exit to IDLE after IDLE_BITS consecutive J samples.
- **Bus reset.**
  - An SE0 counter counts clks, not strobes, while the synchronized line is SE0, and saturates.
  - `usb_reset` is high while the counter is ≥ RESET_CLKS; it clears in the first non-SE0 clk.
  - The FSM treats reset SE0 as EOP/ERROR as normal.
- **Simultaneous events.** A strobe that both completes a byte and is followed by SE0 at the next strobe gives `rx_valid` first, then `rx_eop`. These are never in the same clk.

## Timing
- Reset values:
  - All outputs 0, `rx_data` = 0x00.
  - FSM in IDLE; phase counter 0; previous sampled state J; SE0 counter 0.
- Synchronizer latency: 2 clks.
- `rx_valid`/`rx_pid`: asserted the clk after the strobe that samples the 8th kept bit. `rx_data` is stable from that clk until the next `rx_valid`.
- `rx_eop`/`rx_error`: asserted the clk after the deciding strobe.
- `rx_active`: rises the clk after the SYNC-completing strobe.
- Tolerance: edge jitter of ±1 clk relative to nominal bit boundaries must decode correctly.
- `rst` mid-packet: next clk all outputs are at reset values; the current packet is dropped with no `rx_error`.

## Configuration
- `USB_RX_PID_CHECK_EN` defined:
  - The first byte must satisfy `rx_data[7:4] == ~rx_data[3:0]`.
  - On a mismatch, `rx_valid`/`rx_pid` are suppressed, `rx_error` pulses and the FSM goes to ERROR.
- Undefined: the first byte is always delivered with `rx_pid`=1 and no check is made.

## Test plan
- ACK packet (SYNC, byte 0xD2, 2-bit SE0, J): exactly one `rx_valid` with `rx_data`=0xD2 and `rx_pid`=1, then one `rx_eop`; `rx_error` stays 0.
- DATA0 packet with bytes 0xC3, 0xFF, 0x01 and correct stuff bits: three `rx_valid` with 0xC3 (pid), 0xFF, 0x01, then `rx_eop`. Repeat with ±1 clk jitter on every edge: same result.
- Seven consecutive decoded 1s in DATA: `rx_error` pulses once, `rx_active` drops, and no `rx_eop` follows. The next clean ACK after 8 J bits decodes correctly.
- SYNC sent as KJKJKKKK: `rx_error`, no `rx_valid`. SE0 after 11 data bits: 1 `rx_valid`, then `rx_error`, no `rx_eop`.
- SE0 held for 130 clks: `usb_reset` rises after RESET_CLKS=120 clks of SE0 (plus sync latency) and falls on the first J.
- PID byte 0xD3 with the macro defined: `rx_error`, no `rx_valid`. Without the macro: `rx_valid`, `rx_pid`=1, `rx_data`=0xD3. Separately, `rst` asserted mid-byte: all outputs 0 the next clk, and the next packet decodes normally.

Source files
------------

// File: rtl/usb_fs_rx_if.sv
// Receive-side bundle of one full-speed USB port: raw D+/D- in, decoded byte stream out.
// master = the receiver (usb_fs_rx), slave = line driver / packet consumer.
interface usb_fs_rx_if;
    logic       dp;
    logic       dm;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_pid;
    logic       rx_eop;
    logic       rx_error;
    logic       usb_reset;

    modport master (
        input  dp, dm,
        output rx_active, rx_valid, rx_data, rx_pid, rx_eop, rx_error, usb_reset
    );

    modport slave (
        output dp, dm,
        input  rx_active, rx_valid, rx_data, rx_pid, rx_eop, rx_error, usb_reset
    );
endinterface

// File: rtl/usb_fs_rx.sv
// Full-speed USB receive front end: 4x oversampled clock recovery, NRZI decode, SYNC, unstuffing.
// Optional PID complement check enabled by defining USB_RX_PID_CHECK_EN.
module usb_fs_rx #(
    parameter int RESET_CLKS = 120,
    parameter int IDLE_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    usb_fs_rx_if.master bus
);
    localparam int SE0_W  = $clog2(RESET_CLKS + 1);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    logic [1:0] w_raw;
    logic [1:0] w_line;

    assign w_raw = {bus.dp, bus.dm};

    // Bit 1 carries D+, bit 0 carries D-; both idle at J after reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta <= LS_J[gi];
                    r_sync <= LS_J[gi];
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                end
            end
            assign w_line[gi] = r_sync;
        end
    endgenerate

    logic [1:0] r_line_prev;
    logic [1:0] r_phase;
    logic [1:0] w_phase;
    logic       w_strobe;

    // Phase is 0 in the clk where a transition is seen, so sampling lands two clks after each edge.
    assign w_phase  = (w_line != r_line_prev) ? 2'd0 : r_phase + 2'd1;
    assign w_strobe = (w_phase == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_prev <= LS_J;
            r_phase     <= 2'd0;
        end else begin
            r_line_prev <= w_line;
            r_phase     <= w_phase;
        end
    end

    logic             w_se0;
    logic [SE0_W-1:0] r_se0_cnt;

    assign w_se0 = (w_line == LS_SE0);

    always_ff @(posedge clk) begin
        if (rst || !w_se0) begin
            r_se0_cnt <= '0;
        end else if (r_se0_cnt != SE0_W'(RESET_CLKS)) begin
            r_se0_cnt <= r_se0_cnt + 1'b1;
        end
    end

    assign bus.usb_reset = w_se0 && (r_se0_cnt >= SE0_W'(RESET_CLKS));

    logic [2:0]        r_state;
    logic [1:0]        r_prev_ls;
    logic [2:0]        r_cnt;
    logic [2:0]        r_ones;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_first;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_rx_active;
    logic              r_rx_valid;
    logic [7:0]        r_rx_data;
    logic              r_rx_pid;
    logic              r_rx_eop;
    logic              r_rx_error;

    logic       w_is_j;
    logic       w_is_k;
    logic       w_is_se;
    logic       w_bit;
    logic [7:0] w_byte;
    logic       w_pid_bad;
    logic       w_fail;

    assign w_is_j  = (w_line == LS_J);
    assign w_is_k  = (w_line == LS_K);
    assign w_is_se = (w_line == LS_SE0) || (w_line == LS_SE1);
    assign w_bit   = (w_line == r_prev_ls);
    assign w_byte  = {w_bit, r_shift[7:1]};

`ifdef USB_RX_PID_CHECK_EN
    assign w_pid_bad = r_first && (w_byte[7:4] != ~w_byte[3:0]);
`else
    assign w_pid_bad = 1'b0;
`endif

    // Every condition that sends the FSM to ERROR, evaluated on the current strobe.
    always_comb begin
        w_fail = 1'b0;
        if (w_strobe) begin
            case (r_state)
                ST_IDLE: w_fail = (w_line == LS_SE1);
                ST_SYNC: w_fail = w_is_se || (w_bit != (r_cnt == 3'd7));
                ST_DATA: w_fail = !w_is_se &&
                                  ((r_ones == 3'd6) ? w_bit : ((r_bitcnt == 3'd7) && w_pid_bad));
                ST_EOP:  w_fail = w_is_k;
                default: w_fail = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prev_ls   <= LS_J;
            r_cnt       <= 3'd0;
            r_ones      <= 3'd0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_first     <= 1'b0;
            r_idle_cnt  <= '0;
            r_rx_active <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_pid    <= 1'b0;
            r_rx_eop    <= 1'b0;
            r_rx_error  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_pid   <= 1'b0;
            r_rx_eop   <= 1'b0;
            r_rx_error <= 1'b0;
            if (w_strobe) begin
                r_prev_ls <= w_line;
            end
            if (w_fail) begin
                r_state     <= ST_ERROR;
                r_rx_error  <= 1'b1;
                r_rx_active <= 1'b0;
                r_idle_cnt  <= '0;
            end else if (w_strobe) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_k) begin
                            r_state <= ST_SYNC;
                            r_cnt   <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (r_cnt == 3'd7) begin
                            r_state     <= ST_DATA;
                            r_rx_active <= 1'b1;
                            r_ones      <= 3'd0;
                            r_bitcnt    <= 3'd0;
                            r_first     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_is_se) begin
                            r_state     <= ST_EOP;
                            r_rx_active <= 1'b0;
                            if (r_bitcnt == 3'd0) begin
                                r_rx_eop <= 1'b1;
                            end else begin
                                r_rx_error <= 1'b1;
                            end
                        end else if (r_ones == 3'd6) begin
                            r_ones <= 3'd0;
                        end else begin
                            r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_rx_valid <= 1'b1;
                                r_rx_pid   <= r_first;
                                r_rx_data  <= w_byte;
                                r_first    <= 1'b0;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (w_is_j) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ERROR: begin
                        if (!w_is_j) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == IDLE_W'(IDLE_BITS - 1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_active = r_rx_active;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_pid    = r_rx_pid;
    assign bus.rx_eop    = r_rx_eop;
    assign bus.rx_error  = r_rx_error;
endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed bench for usb_fs_rx: builds NRZI line waveforms per clk and checks the decoded event stream.
`timescale 1ns/1ps
module tb_usb_fs_rx;
    localparam logic [1:0] J  = 2'b10;
    localparam logic [1:0] K  = 2'b01;
    localparam logic [1:0] S0 = 2'b00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_fs_rx_if bus ();
    usb_fs_rx dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Event log: [11:10] 1=byte 2=eop 3=error, [8] pid, [7:0] data; 0xFFF = byte with eop/error in the same clk.
    logic [11:0] ev[$];
    logic [1:0]  cur;
    logic [1:0]  bq[$];
    int          ones;
    int          pj = 0;
    int          ec = 0;
    int          pat[4] = '{1, 0, -1, 0};

    always @(negedge clk) begin
        if (bus.rx_valid && (bus.rx_eop || bus.rx_error)) ev.push_back(12'hFFF);
        if (bus.rx_valid) ev.push_back({2'b01, 1'b0, bus.rx_pid, bus.rx_data});
        if (bus.rx_eop)   ev.push_back(12'h800);
        if (bus.rx_error) ev.push_back(12'hC00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_ev(input string tag, input logic [11:0] e);
        logic [11:0] got;
        got = 12'hEEE;
        if (ev.size() > 0) got = ev.pop_front();
        check(tag, {20'd0, got}, {20'd0, e});
    endtask

    task automatic exp_none(input string tag);
        check(tag, ev.size(), 0);
    endtask

    task automatic drive(input logic [1:0] ls, input int n);
        {bus.dp, bus.dm} = ls;
        repeat (n) @(negedge clk);
    endtask

    task automatic nrzi(input bit b);
        if (!b) cur = (cur == J) ? K : J;
        bq.push_back(cur);
    endtask

    task automatic sync_pat();
        for (int i = 0; i < 7; i++) nrzi(1'b0);
        nrzi(1'b1);
        ones = 0;
    endtask

    task automatic byte_out(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            nrzi(v[i]);
            ones = v[i] ? ones + 1 : 0;
            if (ones == 6) begin
                nrzi(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic eop(input int nidle);
        bq.push_back(S0);
        bq.push_back(S0);
        cur = J;
        for (int i = 0; i < nidle; i++) bq.push_back(J);
    endtask

    // Plays the bit queue; with jit set, each transition is displaced by +1,0,-1,0 clks in turn.
    task automatic play(input bit jit);
        int i;
        i = 0;
        while (i < bq.size()) begin
            int n;
            int nj;
            n = 1;
            while ((i + n < bq.size()) && (bq[i + n] == bq[i])) n++;
            if (i + n < bq.size()) begin
                nj = jit ? pat[ec % 4] : 0;
                ec++;
            end else begin
                nj = pj;
            end
            drive(bq[i], 4 * n + nj - pj);
            pj = nj;
            i += n;
        end
        bq.delete();
    endtask

    task automatic ack_packet(input string tag);
        sync_pat();
        byte_out(8'hD2);
        eop(6);
        play(1'b0);
        exp_ev({tag, "_pid"}, 12'h5D2);
        exp_ev({tag, "_eop"}, 12'h800);
        exp_none({tag, "_extra"});
    endtask

    initial begin
        rst = 1'b1;
        bus.dp = 1'b1;
        bus.dm = 1'b0;
        cur = J;
        ones = 0;
        repeat (3) @(negedge clk);
        check("rst_active", bus.rx_active, 0);
        check("rst_valid",  bus.rx_valid, 0);
        check("rst_data",   bus.rx_data, 0);
        check("rst_pid",    bus.rx_pid, 0);
        check("rst_eop",    bus.rx_eop, 0);
        check("rst_error",  bus.rx_error, 0);
        check("rst_usbrst", bus.usb_reset, 0);
        rst = 1'b0;
        drive(J, 20);

        // ACK packet with an rx_active probe before the EOP
        sync_pat();
        byte_out(8'hD2);
        play(1'b0);
        check("ack_active", bus.rx_active, 1);
        eop(6);
        play(1'b0);
        exp_ev("ack_pid", 12'h5D2);
        exp_ev("ack_eop", 12'h800);
        exp_none("ack_extra");
        check("ack_active_low", bus.rx_active, 0);
        $display("txn ack: done");

        // DATA0 C3 FF 01, nominal then jittered edges
        for (int jt = 0; jt < 2; jt++) begin
            sync_pat();
            byte_out(8'hC3);
            byte_out(8'hFF);
            byte_out(8'h01);
            eop(6);
            play(jt[0]);
            exp_ev("d0_b0", 12'h5C3);
            exp_ev("d0_b1", 12'h4FF);
            exp_ev("d0_b2", 12'h401);
            exp_ev("d0_eop", 12'h800);
            exp_none("d0_extra");
            $display("txn data0 jitter=%0d: done", jt);
        end

        // Seven decoded ones: stuff error, no eop, then a clean ACK
        sync_pat();
        for (int i = 0; i < 7; i++) nrzi(1'b1);
        eop(10);
        play(1'b0);
        exp_ev("stuff_err", 12'hC00);
        exp_none("stuff_extra");
        check("stuff_active", bus.rx_active, 0);
        ack_packet("ack2");
        $display("txn stuff error + ack: done");

        // Corrupt SYNC KJKJKKKK
        bq.push_back(K); bq.push_back(J); bq.push_back(K); bq.push_back(J);
        for (int i = 0; i < 4; i++) bq.push_back(K);
        cur = J;
        for (int i = 0; i < 10; i++) bq.push_back(J);
        play(1'b0);
        exp_ev("badsync_err", 12'hC00);
        exp_none("badsync_extra");
        $display("txn bad sync: done");

        // SE0 after 11 data bits
        sync_pat();
        byte_out(8'hD2);
        nrzi(1'b0); nrzi(1'b1); nrzi(1'b0);
        eop(10);
        play(1'b0);
        exp_ev("partial_pid", 12'h5D2);
        exp_ev("partial_err", 12'hC00);
        exp_none("partial_extra");
        $display("txn partial byte: done");

        // PID 0xD3 (complement mismatch)
        sync_pat();
        byte_out(8'hD3);
        eop(10);
        play(1'b0);
`ifdef USB_RX_PID_CHECK_EN
        exp_ev("pidchk_err", 12'hC00);
`else
        exp_ev("pidchk_pid", 12'h5D3);
        exp_ev("pidchk_eop", 12'h800);
`endif
        exp_none("pidchk_extra");
        $display("txn pid D3: done");

        // Bus reset: 130 clks of SE0
        {bus.dp, bus.dm} = S0;
        repeat (121) @(negedge clk);
        check("busrst_pre", bus.usb_reset, 0);
        @(negedge clk);
        check("busrst_rise", bus.usb_reset, 1);
        repeat (8) @(negedge clk);
        check("busrst_hold", bus.usb_reset, 1);
        {bus.dp, bus.dm} = J;
        @(negedge clk);
        check("busrst_sync", bus.usb_reset, 1);
        @(negedge clk);
        check("busrst_fall", bus.usb_reset, 0);
        drive(J, 40);
        exp_none("busrst_events");
        $display("txn bus reset: done");

        // rst mid-byte, then a clean ACK
        sync_pat();
        nrzi(1'b0); nrzi(1'b1); nrzi(1'b0); nrzi(1'b0);
        play(1'b0);
        check("midrst_active_pre", bus.rx_active, 1);
        rst = 1'b1;
        {bus.dp, bus.dm} = J;
        cur = J;
        @(negedge clk);
        check("midrst_active", bus.rx_active, 0);
        check("midrst_valid",  bus.rx_valid, 0);
        check("midrst_data",   bus.rx_data, 0);
        check("midrst_pid",    bus.rx_pid, 0);
        check("midrst_eop",    bus.rx_eop, 0);
        check("midrst_error",  bus.rx_error, 0);
        check("midrst_usbrst", bus.usb_reset, 0);
        rst = 1'b0;
        drive(J, 40);
        exp_none("midrst_events");
        ack_packet("ack3");
        $display("txn reset mid-byte + ack: done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
